// File: rtl/hawk_axi_wr_buf.sv
// rtl/hawk_axi_wr_buf.sv - AW/W request FIFOs feeding a 512-bit AXI4 write master with B-response tracking
module hawk_axi_wr_buf #(
    parameter int         AW_DEPTH  = 4,
    parameter int         W_DEPTH   = 4,
    parameter int         MAX_OUTST = 16,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_awvalid,
    input  logic [63:0]                    req_addr,
    input  logic                           req_wvalid,
    input  logic [511:0]                   req_data,
    input  logic [63:0]                    req_strb,
    output logic                           req_awready,
    output logic                           req_wready,
    output logic [3:0]                     m_awid,
    output logic [63:0]                    m_awaddr,
    output logic [7:0]                     m_awlen,
    output logic [2:0]                     m_awsize,
    output logic [1:0]                     m_awburst,
    output logic                           m_awvalid,
    input  logic                           m_awready,
    output logic [511:0]                   m_wdata,
    output logic [63:0]                    m_wstrb,
    output logic                           m_wlast,
    output logic                           m_wvalid,
    input  logic                           m_wready,
    input  logic [3:0]                     m_bid,
    input  logic [1:0]                     m_bresp,
    input  logic                           m_bvalid,
    output logic                           m_bready,
    output logic                           bresp_vld,
    output logic                           bresp_ok,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           idle,
    output logic                           err_ovf,
    output logic                           err_bus
);
    localparam int AP = $clog2(AW_DEPTH);
    localparam int AC = $clog2(AW_DEPTH + 1);
    localparam int WP = $clog2(W_DEPTH);
    localparam int WC = $clog2(W_DEPTH + 1);
    localparam int OC = $clog2(MAX_OUTST + 1);
    localparam logic [AC-1:0] AW_FULL   = AC'(AW_DEPTH);
    localparam logic [WC-1:0] W_FULL    = WC'(W_DEPTH);
    localparam logic [OC-1:0] OUTST_MAX = OC'(MAX_OUTST);

    logic [63:0]   aw_mem [AW_DEPTH];
    logic [AP-1:0] aw_wp, aw_rp;
    logic [AC-1:0] aw_cnt;
    logic [575:0]  w_mem [W_DEPTH];
    logic [WP-1:0] w_wp, w_rp;
    logic [WC-1:0] w_cnt;
    logic          aw_push, aw_pop, w_push, w_pop, b_hs, b_dec;

    // B responses are in order on a single ID, so the returned id carries no information
    logic unused_bid;
    assign unused_bid = ^m_bid;

    assign m_awid    = AXI_ID;
    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'd6;
    assign m_awburst = 2'b01;
    assign m_wlast   = 1'b1;
    assign m_bready  = 1'b1;

    // Ready reflects the pre-pop count, so a full FIFO never accepts a same-cycle push
    assign req_awready = aw_cnt < AW_FULL;
    assign req_wready  = w_cnt < W_FULL;
    assign aw_push     = req_awvalid && req_awready;
    assign w_push      = req_wvalid && req_wready;

    // outst_cnt only grows on an AW handshake, so an asserted m_awvalid cannot be withdrawn by the cap
    assign m_awvalid = (aw_cnt != '0) && (outst_cnt < OUTST_MAX);
    assign m_awaddr  = aw_mem[aw_rp];
    assign m_wvalid  = (w_cnt != '0);
    assign {m_wstrb, m_wdata} = w_mem[w_rp];

    assign aw_pop = m_awvalid && m_awready;
    assign w_pop  = m_wvalid && m_wready;
    assign b_hs   = m_bvalid && m_bready;
    assign b_dec  = b_hs && (outst_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (aw_push) aw_mem[aw_wp] <= req_addr;
        if (w_push) w_mem[w_wp] <= {req_strb, req_data};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_wp     <= '0;
            aw_rp     <= '0;
            aw_cnt    <= '0;
            w_wp      <= '0;
            w_rp      <= '0;
            w_cnt     <= '0;
            outst_cnt <= '0;
            bresp_vld <= 1'b0;
            bresp_ok  <= 1'b0;
            idle      <= 1'b1;
            err_ovf   <= 1'b0;
            err_bus   <= 1'b0;
        end else begin
            if (aw_push) aw_wp <= aw_wp + AP'(1);
            if (aw_pop) aw_rp <= aw_rp + AP'(1);
            case ({aw_push, aw_pop})
                2'b10:   aw_cnt <= aw_cnt + AC'(1);
                2'b01:   aw_cnt <= aw_cnt - AC'(1);
                default: aw_cnt <= aw_cnt;
            endcase

            if (w_push) w_wp <= w_wp + WP'(1);
            if (w_pop) w_rp <= w_rp + WP'(1);
            case ({w_push, w_pop})
                2'b10:   w_cnt <= w_cnt + WC'(1);
                2'b01:   w_cnt <= w_cnt - WC'(1);
                default: w_cnt <= w_cnt;
            endcase

            // A B with nothing outstanding is flagged but never underflows the count
            case ({aw_pop, b_dec})
                2'b10:   outst_cnt <= outst_cnt + OC'(1);
                2'b01:   outst_cnt <= outst_cnt - OC'(1);
                default: outst_cnt <= outst_cnt;
            endcase

            bresp_vld <= b_hs;
            bresp_ok  <= b_hs && (m_bresp == 2'b00);
            idle      <= (aw_cnt == '0) && (w_cnt == '0) && (outst_cnt == '0);
            if ((req_awvalid && !req_awready) || (req_wvalid && !req_wready))
                err_ovf <= 1'b1;
            if (b_hs && ((m_bresp != 2'b00) || (outst_cnt == '0)))
                err_bus <= 1'b1;
        end
    end
endmodule
